// File: rtl/of_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : of_write_ctrl
//  Brief    : Output-feature write controller. Walks a scratchpad linearly,
//             framing each element into a {start, end, data} word and pushing
//             it into an output buffer, row_len elements per row, num_rows
//             rows per request. Honours buffer-full backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module of_write_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CNT_W-1:0]    row_len,
    input  logic [CNT_W-1:0]    num_rows,
    input  logic                full,
    input  logic [DATA_W-1:0]   sp_rdata,
    output logic                sp_ren,
    output logic [ADDR_W-1:0]   sp_raddr,
    output logic                buf_wen,
    output logic [DATA_W+1:0]   buf_wdata,
    output logic                busy,
    output logic                done
);

    // Explicit 3-bit encoding keeps the state register width fixed.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_PUSH  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t                 state_q;

    // Transfer geometry captured when a request is accepted.
    logic [CNT_W-1:0]       len_q;
    logic [CNT_W-1:0]       rows_q;

    // Walk position: scratchpad address, element within row, row index.
    logic [ADDR_W-1:0]      addr_q;
    logic [CNT_W-1:0]       elem_q;
    logic [CNT_W-1:0]       row_q;

    // Framed word waiting to be pushed: {start_bit, end_bit, element}.
    logic [DATA_W+1:0]      hold_q;

    // Registered output flags, set alongside the transition into their state.
    logic                   sp_ren_q;
    logic                   push_q;
    logic                   busy_q;
    logic                   done_q;

    // Position decode shared by the framing bits and the PUSH bookkeeping.
    logic                   elem_first;
    logic                   elem_last;
    logic                   row_last;
    logic                   start_ok;

    assign elem_first = (elem_q == '0);
    assign elem_last  = (elem_q == (len_q - CNT_ONE));
    assign row_last   = (row_q == (rows_q - CNT_ONE));
    assign start_ok   = (row_len != '0) && (num_rows != '0);

    // Controller FSM: state, counters, hold register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            rows_q   <= '0;
            addr_q   <= '0;
            elem_q   <= '0;
            row_q    <= '0;
            hold_q   <= '0;
            sp_ren_q <= 1'b0;
            push_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        // Geometry is frozen here; input changes are ignored
                        // until the controller returns to IDLE.
                        len_q  <= row_len;
                        rows_q <= num_rows;
                        addr_q <= '0;
                        elem_q <= '0;
                        row_q  <= '0;
                        busy_q <= 1'b1;
                        if (start_ok) begin
                            state_q  <= S_FETCH;
                            sp_ren_q <= 1'b1;
                        end else begin
                            // Empty transfer: report completion straight away.
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end

                S_FETCH: begin
                    // Read issued this cycle; data returns during LATCH.
                    state_q  <= S_LATCH;
                    sp_ren_q <= 1'b0;
                end

                S_LATCH: begin
                    hold_q  <= {elem_first, elem_last, sp_rdata};
                    state_q <= S_PUSH;
                    push_q  <= 1'b1;
                end

                S_PUSH: begin
                    // While the buffer is full the word simply waits in hold_q.
                    if (!full) begin
                        addr_q <= addr_q + ADDR_ONE;
                        push_q <= 1'b0;
                        if (elem_last) begin
                            elem_q <= '0;
                            row_q  <= row_q + CNT_ONE;
                            if (row_last) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q  <= S_FETCH;
                                sp_ren_q <= 1'b1;
                            end
                        end else begin
                            elem_q   <= elem_q + CNT_ONE;
                            state_q  <= S_FETCH;
                            sp_ren_q <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q  <= S_IDLE;
                    sp_ren_q <= 1'b0;
                    push_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    // The write strobe must drop in the same cycle full rises, so it is the
    // only output combining a registered flag with a live input.
    assign buf_wen   = push_q & ~full;
    assign buf_wdata = hold_q;
    assign sp_ren    = sp_ren_q;
    assign sp_raddr  = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_of_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_of_write_ctrl
//  Brief    : Self-checking bench for of_write_ctrl. A behavioural model lists
//             the expected words and addresses of each transfer and predicts
//             the cycle of every read, write and completion pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_of_write_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BUDGET = 4000;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [CNT_W-1:0]    row_len;
    logic [CNT_W-1:0]    num_rows;
    logic                full;
    logic [DATA_W-1:0]   sp_rdata;
    logic                sp_ren;
    logic [ADDR_W-1:0]   sp_raddr;
    logic                buf_wen;
    logic [DATA_W+1:0]   buf_wdata;
    logic                busy;
    logic                done;

    logic [DATA_W-1:0]   mem [DEPTH];

    int n_cmp = 0;
    int n_err = 0;

    of_write_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .row_len   (row_len),
        .num_rows  (num_rows),
        .full      (full),
        .sp_rdata  (sp_rdata),
        .sp_ren    (sp_ren),
        .sp_raddr  (sp_raddr),
        .buf_wen   (buf_wen),
        .buf_wdata (buf_wdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Scratchpad: synchronous read, data valid the cycle after sp_ren.
    always @(posedge clk) begin
        if (sp_ren) sp_rdata <= mem[sp_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".sp_ren"},    32'(sp_ren),    32'd0);
        chk({tag, ".sp_raddr"},  32'(sp_raddr),  32'd0);
        chk({tag, ".buf_wen"},   32'(buf_wen),   32'd0);
        chk({tag, ".buf_wdata"}, 32'(buf_wdata), 32'd0);
        chk({tag, ".busy"},      32'(busy),      32'd0);
        chk({tag, ".done"},      32'(done),      32'd0);
    endtask

    // Reset in the middle of a transfer, then confirm it is abandoned.
    task automatic do_abort();
        #1 rst = 1'b1;
        #1 check_reset("abort");
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("abort.hold_wen", 32'(buf_wen), 32'd0);
            chk("abort.hold_busy", 32'(busy), 32'd0);
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("abort.idle_wen",  32'(buf_wen), 32'd0);
            chk("abort.idle_ren",  32'(sp_ren),  32'd0);
            chk("abort.idle_busy", 32'(busy),    32'd0);
            chk("abort.idle_done", 32'(done),    32'd0);
        end
    endtask

    // mode 0: no backpressure, en quiet; mode 1: random full and random en
    // noise while busy; mode 2: full high in cycles 3..7 after the request.
    task automatic run_xfer(input int L, input int N, input int mode, input int abort_after);
        logic [DATA_W+1:0] exp_q[$];
        logic [ADDR_W-1:0] exp_addr[$];
        int total;
        int next_fetch;
        int next_push;
        int done_cyc;
        int n_wr;
        total = L * N;
        for (int r = 0; r < N; r++) begin
            for (int e = 0; e < L; e++) begin
                int a;
                a = (r * L + e) % DEPTH;
                exp_q.push_back({(e == 0), (e == L - 1), mem[a]});
                exp_addr.push_back(ADDR_W'(a));
            end
        end
        n_wr = 0;
        if (total == 0) begin
            next_fetch = -1;
            next_push  = -1;
            done_cyc   = 1;
        end else begin
            next_fetch = 1;
            next_push  = 3;
            done_cyc   = 1000000;
        end

        @(negedge clk);
        en       = 1'b1;
        row_len  = CNT_W'(L);
        num_rows = CNT_W'(N);
        full     = 1'b0;

        for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
            if (cyc > BUDGET) begin
                chk("timeout", 32'd1, 32'd0);
                en = 1'b0;
                return;
            end
            @(negedge clk);
            case (mode)
                1:       full = ($urandom_range(0, 2) == 0);
                2:       full = (cyc >= 3 && cyc <= 7);
                default: full = 1'b0;
            endcase
            if (mode == 1 && cyc <= done_cyc) begin
                en       = 1'($urandom_range(0, 1));
                row_len  = CNT_W'($urandom);
                num_rows = CNT_W'($urandom);
            end else begin
                en = 1'b0;
            end
            #1;
            chk("buf_wen", 32'(buf_wen), 32'((cyc == next_push) && !full));
            chk("sp_ren",  32'(sp_ren),  32'(cyc == next_fetch));
            if (cyc == next_fetch)
                chk("sp_raddr", 32'(sp_raddr), 32'(exp_addr[n_wr]));
            if (cyc == next_push)
                chk("buf_wdata", 32'(buf_wdata), 32'(exp_q[n_wr]));
            chk("done", 32'(done), 32'(cyc == done_cyc));
            chk("busy", 32'(busy), 32'(cyc <= done_cyc));
            if (cyc == next_push) begin
                if (full) begin
                    next_push++;
                end else begin
                    n_wr++;
                    if (n_wr == total) begin
                        done_cyc   = cyc + 1;
                        next_fetch = -1;
                        next_push  = -1;
                    end else begin
                        next_fetch = cyc + 1;
                        next_push  = cyc + 3;
                    end
                    if (abort_after > 0 && n_wr == abort_after) begin
                        do_abort();
                        return;
                    end
                end
            end
        end
        en = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        full     = 1'b0;
        row_len  = '0;
        num_rows = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i + 1);
        #1 check_reset("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_xfer(3, 2, 0, 0);     // two rows of three, no backpressure
        run_xfer(1, 3, 0, 0);     // single-element rows: start and end together
        run_xfer(2, 1, 2, 0);     // five-cycle stall on the first push
        run_xfer(0, 4, 0, 0);     // empty row length
        run_xfer(3, 3, 0, 2);     // reset after the second write
        run_xfer(2, 1, 0, 0);     // fresh request after the abort

        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
        for (int t = 0; t < 14; t++)
            run_xfer($urandom_range(0, 5), $urandom_range(0, 4), 1, 0);
        run_xfer(9, 8, 1, 0);     // long enough to wrap the address counter
        run_xfer(4, 0, 1, 0);     // empty row count

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
